// File: rtl/present_pkg.sv
// Shared encodings and widths for the serial PRESENT-80 encryptor.
package present_pkg;

   localparam int STATE_W    = 64;
   localparam int KEY_W      = 80;
   localparam int NIB_W      = 4;
   localparam int RND_W      = 5;
   localparam int ROUNDS_DEF = 31;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDKEY = 3'd1,
      SBOX   = 3'd2,
      PLAYER = 3'd3,
      KEYUPD = 3'd4,
      FINAL  = 3'd5,
      DONE   = 3'd6
   } fsm_e;

endpackage

// File: rtl/present_serial_enc_sbox.sv
// PRESENT 4-bit substitution box, purely combinational.
module s_box (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = 4'h0;
      case (din)
         4'h0: dout = 4'hC;
         4'h1: dout = 4'h5;
         4'h2: dout = 4'h6;
         4'h3: dout = 4'hB;
         4'h4: dout = 4'h9;
         4'h5: dout = 4'h0;
         4'h6: dout = 4'hA;
         4'h7: dout = 4'hD;
         4'h8: dout = 4'h3;
         4'h9: dout = 4'hE;
         4'hA: dout = 4'hF;
         4'hB: dout = 4'h8;
         4'hC: dout = 4'h4;
         4'hD: dout = 4'h7;
         4'hE: dout = 4'h1;
         4'hF: dout = 4'h2;
         default: dout = 4'h0;
      endcase
   end

endmodule

// File: rtl/present_serial_enc.sv
// Nibble-serial PRESENT-80 encryptor sharing one S-box between the
// state substitution and the key schedule.
module present_serial_enc
   import present_pkg::*;
#(
   parameter int ROUNDS = ROUNDS_DEF
) (
   input  logic               Clk_ik,
   input  logic               Reset_irn,
   input  logic               Start_i,
   input  logic [STATE_W-1:0] Data_ib,
   input  logic [KEY_W-1:0]   Key_ib,
   output logic               Busy_o,
   output logic               Done_o,
   output logic [STATE_W-1:0] Data_ob
);

   fsm_e               fsm, fsm_nxt;
   logic [STATE_W-1:0] state;
   logic [KEY_W-1:0]   key;
   logic [RND_W-1:0]   round;
   logic [NIB_W-1:0]   nib;

   logic [STATE_W-1:0] player;
   logic [KEY_W-1:0]   key_rot;
   logic [KEY_W-1:0]   key_nxt;
   logic [3:0]         sbox_in, sbox_out;

   // pLayer: bit i moves to (16*i) mod 63, bit 63 is fixed
   for (genvar i = 0; i < STATE_W - 1; i++) begin : g_player
      assign player[(16 * i) % 63] = state[i];
   end
   assign player[STATE_W-1] = state[STATE_W-1];

   assign key_rot = {key[18:0], key[KEY_W-1:19]};
   assign key_nxt = {sbox_out, key_rot[75:20], key_rot[19:15] ^ round, key_rot[14:0]};

   always_comb begin
      sbox_in = 4'h0;
      case (fsm)
         SBOX:    sbox_in = state[3:0];
         KEYUPD:  sbox_in = key_rot[KEY_W-1:KEY_W-4];
         default: sbox_in = 4'h0;
      endcase
   end

   s_box u_sbox (
      .din  (sbox_in),
      .dout (sbox_out)
   );

   always_ff @(posedge Clk_ik or negedge Reset_irn) begin
      if (!Reset_irn) fsm <= IDLE;
      else            fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (Start_i) fsm_nxt = ADDKEY;
         ADDKEY:  fsm_nxt = SBOX;
         SBOX:    if (nib == '1) fsm_nxt = PLAYER;
         PLAYER:  fsm_nxt = KEYUPD;
         KEYUPD:  fsm_nxt = (round == RND_W'(ROUNDS)) ? FINAL : ADDKEY;
         FINAL:   fsm_nxt = DONE;
         DONE:    fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk_ik or negedge Reset_irn) begin
      if (!Reset_irn) begin
         state   <= '0;
         key     <= '0;
         round   <= '0;
         nib     <= '0;
         Data_ob <= '0;
      end else begin
         case (fsm)
            IDLE: if (Start_i) begin
               state <= Data_ib;
               key   <= Key_ib;
               round <= RND_W'(1);
               nib   <= '0;
            end
            ADDKEY: state <= state ^ key[KEY_W-1:16];
            // rotate right one nibble per cycle; 16 steps restore the order
            SBOX: begin
               state <= {sbox_out, state[STATE_W-1:4]};
               nib   <= nib + NIB_W'(1);
            end
            PLAYER: state <= player;
            KEYUPD: begin
               key <= key_nxt;
               if (round != RND_W'(ROUNDS)) round <= round + RND_W'(1);
            end
            FINAL: Data_ob <= state ^ key[KEY_W-1:16];
            default: ;
         endcase
      end
   end

   assign Busy_o = (fsm != IDLE);
   assign Done_o = (fsm == DONE);

endmodule

// File: tb/tb_present_serial_enc.sv
// Directed-vector bench for present_serial_enc: known-answer table plus
// back-to-back, mid-run reset and ignored-start sequences.
module tb_present_serial_enc;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] data_in;
   logic [79:0] key_in;
   logic        busy;
   logic        done;
   logic [63:0] data_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] d;
      logic [79:0] k;
      logic [63:0] ct;
   } vec_t;

   vec_t vecs[3];

   present_serial_enc #(.ROUNDS(31)) dut (
      .Clk_ik    (clk),
      .Reset_irn (rst_n),
      .Start_i   (start),
      .Data_ib   (data_in),
      .Key_ib    (key_in),
      .Busy_o    (busy),
      .Done_o    (done),
      .Data_ob   (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Start_i is already high; the next rising edge accepts the operation.
   // poke >= 0 pulses Start_i with different inputs after that many cycles.
   task automatic wait_result(input logic [63:0] exp, input int poke, input string name);
      int cnt;
      bit got;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      data_in = {$urandom, $urandom};
      key_in  = {$urandom, $urandom, $urandom};
      chk({name, "_busy"}, 80'(busy), 80'(1));
      cnt = 0;
      got = 1'b0;
      while (cnt < 700 && !got) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (done) got = 1'b1;
         else if (cnt == poke) begin
            start   = 1'b1;
            data_in = 64'hDEAD_BEEF_0123_4567;
            key_in  = '1;
         end else start = 1'b0;
      end
      start = 1'b0;
      chk({name, "_latency"}, 80'(cnt), 80'(590));
      chk({name, "_data"}, 80'(data_out), 80'(exp));
      @(negedge clk);
      chk({name, "_done_width"}, 80'(done), 80'(0));
      chk({name, "_idle"}, 80'(busy), 80'(0));
   endtask

   initial begin
      int npulse;
      int edges[2];
      int extra;

      vecs[0] = '{d: 64'h0,                  k: 80'h0,                        ct: 64'h5579C1387B228445};
      vecs[1] = '{d: 64'h0,                  k: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, ct: 64'hE72C46C0F5945049};
      vecs[2] = '{d: 64'hFFFF_FFFF_FFFF_FFFF, k: 80'h0,                        ct: 64'hA112FFC72F68417B};

      rst_n   = 1'b0;
      start   = 1'b0;
      data_in = '0;
      key_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 80'(busy), 80'(0));
      chk("rst_done", 80'(done), 80'(0));
      chk("rst_data", 80'(data_out), 80'(0));
      rst_n = 1'b1;

      // known-answer table
      for (int v = 0; v < 3; v++) begin
         @(negedge clk);
         data_in = vecs[v].d;
         key_in  = vecs[v].k;
         start   = 1'b1;
         wait_result(vecs[v].ct, -1, $sformatf("kat%0d", v));
      end

      // Start_i during SBOX must be ignored
      @(negedge clk);
      data_in = '0;
      key_in  = '0;
      start   = 1'b1;
      wait_result(64'h5579C1387B228445, 5, "sbox_poke");
      extra = 0;
      repeat (600) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("sbox_poke_no_extra", 80'(extra), 80'(0));

      // Start_i held high: second op accepted in first IDLE cycle after DONE
      do_reset();
      data_in = '1;
      key_in  = '1;
      start   = 1'b1;
      npulse  = 0;
      edges   = '{0, 0};
      for (int c = 1; c <= 1200; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (npulse < 2) edges[npulse] = c;
            npulse++;
            chk("b2b_data", 80'(data_out), 80'(64'h3333DCD3213210D2));
         end
      end
      start = 1'b0;
      chk("b2b_pulses", 80'(npulse), 80'(2));
      chk("b2b_first", 80'(edges[0]), 80'(591));
      // 591 cycles separate the pulses, so their edges differ by 592
      chk("b2b_period", 80'(edges[1] - edges[0]), 80'(592));

      // reset mid-run aborts, restart on first edge after release
      do_reset();
      data_in = '1;
      key_in  = '1;
      start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      repeat (299) begin
         @(negedge clk);
         if (done) extra++;
      end
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 80'(busy), 80'(0));
      chk("abort_done", 80'(done), 80'(0));
      chk("abort_data", 80'(data_out), 80'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      data_in = '0;
      key_in  = '0;
      start   = 1'b1;
      wait_result(64'h5579C1387B228445, -1, "restart");
      chk("abort_no_done", 80'(extra), 80'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
